// File: rtl/div_pkg.sv
// div_pkg: shared state encoding and sizing constants for the iterative divider.
package div_pkg;
   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} div_state_e;
   localparam int DIV_WIDTH = 32;
   localparam int DIV_CNT_W = $clog2(DIV_WIDTH);
   localparam int QUO_LSB   = DIV_WIDTH;
   localparam int REM_LSB   = 0;
endpackage

// File: rtl/div_step.sv
// div_step: one combinational radix-2 restoring step (shift in a dividend bit, trial-subtract).
module div_step
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic [WIDTH-1:0] rem,
   input  logic             din,
   input  logic [WIDTH-1:0] dsr,
   output logic [WIDTH-1:0] rem_nx,
   output logic             q_bit
);
   logic [WIDTH:0] sh;
   always_comb begin
      sh     = {rem, din};
      q_bit  = sh >= {1'b0, dsr};
      rem_nx = q_bit ? WIDTH'(sh - {1'b0, dsr}) : sh[WIDTH-1:0];
   end
endmodule

// File: rtl/iter_divider.sv
// iter_divider: radix-2 restoring divider, one quotient bit per cycle, stream handshake.
// Define DIV_EARLY_OUT_EN to skip iteration for a zero divisor or |dividend| < |divisor|.
module iter_divider
   import div_pkg::*;
#(
   parameter int SIGNED = 1,
   parameter int WIDTH  = DIV_WIDTH
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               s_axis_divisor_tvalid,
   output logic               s_axis_divisor_tready,
   input  logic [WIDTH-1:0]   s_axis_divisor_tdata,
   input  logic               s_axis_dividend_tvalid,
   output logic               s_axis_dividend_tready,
   input  logic [WIDTH-1:0]   s_axis_dividend_tdata,
   output logic               m_axis_dout_tvalid,
   input  logic               m_axis_dout_tready,
   output logic [2*WIDTH-1:0] m_axis_dout_tdata,
   input  logic               cancel
);
   localparam int CW = $clog2(WIDTH);
   div_state_e       state;
   logic [WIDTH-1:0] qd, dsr, rem, rem_nx, a_mag, b_mag;
   logic [CW-1:0]    cnt;
   logic             q_neg, r_neg, div0, q_bit, a_neg, b_neg, take;
   assign a_neg = (SIGNED != 0) & s_axis_dividend_tdata[WIDTH-1];
   assign b_neg = (SIGNED != 0) & s_axis_divisor_tdata[WIDTH-1];
   assign a_mag = a_neg ? -s_axis_dividend_tdata : s_axis_dividend_tdata;
   assign b_mag = b_neg ? -s_axis_divisor_tdata : s_axis_divisor_tdata;
   assign take  = resetn & (state == IDLE) & s_axis_divisor_tvalid & s_axis_dividend_tvalid & ~cancel;
   assign s_axis_divisor_tready  = take;
   assign s_axis_dividend_tready = take;
   // qd holds the dividend magnitude shifting out MSB-first while quotient bits shift in
   div_step #(.WIDTH(WIDTH)) u_step (.rem(rem), .din(qd[WIDTH-1]), .dsr(dsr), .rem_nx(rem_nx), .q_bit(q_bit));
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state              <= IDLE;
         qd                 <= '0;
         dsr                <= '0;
         rem                <= '0;
         cnt                <= '0;
         q_neg              <= 1'b0;
         r_neg              <= 1'b0;
         div0               <= 1'b0;
         m_axis_dout_tvalid <= 1'b0;
         m_axis_dout_tdata  <= '0;
      end else begin
         case (state)
            IDLE: if (take) begin
               qd    <= a_mag;
               dsr   <= b_mag;
               rem   <= '0;
               cnt   <= '0;
               q_neg <= a_neg ^ b_neg;
               r_neg <= a_neg;
               div0  <= b_mag == '0;
               state <= CALC;
`ifdef DIV_EARLY_OUT_EN
               if (b_mag == '0 || a_mag < b_mag) begin
                  qd    <= (b_mag == '0) ? '1 : '0;
                  rem   <= a_mag;
                  state <= FIX;
               end
`endif
            end
            CALC: if (cancel) state <= IDLE;
            else begin
               rem   <= rem_nx;
               qd    <= {qd[WIDTH-2:0], q_bit};
               cnt   <= cnt + 1'b1;
               state <= (cnt == CW'(WIDTH - 1)) ? FIX : CALC;
            end
            // a zero divisor keeps the raw all-ones quotient; remainder negation restores the dividend
            FIX: if (cancel) state <= IDLE;
            else begin
               m_axis_dout_tdata  <= {(q_neg & ~div0) ? -qd : qd, r_neg ? -rem : rem};
               m_axis_dout_tvalid <= 1'b1;
               state              <= DONE;
            end
            DONE: if (cancel || m_axis_dout_tready) begin
               m_axis_dout_tvalid <= 1'b0;
               state              <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_iter_divider.sv
// tb_iter_divider: directed vector table plus handshake corner sequences for signed and unsigned instances.
module tb_iter_divider;
   import div_pkg::*;
`ifdef DIV_EARLY_OUT_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif
   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] es;
      logic [63:0] eu;
   } vec_t;
   logic        clk = 1'b0, resetn, va, vb, rdy, cancel;
   logic [31:0] a, b;
   logic        s_ra, s_rb, s_v, u_ra, u_rb, u_v;
   logic [63:0] s_d, u_d;
   int          checks = 0, errors = 0;
   vec_t        tbl[12];
   always #5 clk = ~clk;
   iter_divider #(.SIGNED(1), .WIDTH(DIV_WIDTH)) u_s (
      .clk(clk), .resetn(resetn),
      .s_axis_divisor_tvalid(vb), .s_axis_divisor_tready(s_rb), .s_axis_divisor_tdata(b),
      .s_axis_dividend_tvalid(va), .s_axis_dividend_tready(s_ra), .s_axis_dividend_tdata(a),
      .m_axis_dout_tvalid(s_v), .m_axis_dout_tready(rdy), .m_axis_dout_tdata(s_d), .cancel(cancel));
   iter_divider #(.SIGNED(0), .WIDTH(DIV_WIDTH)) u_u (
      .clk(clk), .resetn(resetn),
      .s_axis_divisor_tvalid(vb), .s_axis_divisor_tready(u_rb), .s_axis_divisor_tdata(b),
      .s_axis_dividend_tvalid(va), .s_axis_dividend_tready(u_ra), .s_axis_dividend_tdata(a),
      .m_axis_dout_tvalid(u_v), .m_axis_dout_tready(rdy), .m_axis_dout_tdata(u_d), .cancel(cancel));
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask
   function automatic int exp_lat(input logic [31:0] x, input logic [31:0] y, input bit sg);
      logic [31:0] mx, my;
      mx = (sg && x[31]) ? -x : x;
      my = (sg && y[31]) ? -y : y;
      return (EARLY && (my == 0 || mx < my)) ? 1 : 33;
   endfunction
   task automatic issue(input string nm, input logic [31:0] x, input logic [31:0] y);
      a = x; b = y; va = 1'b1; vb = 1'b1;
      #1 chk({nm, "_rdy"}, {s_ra, s_rb, u_ra, u_rb}, 4'hF);
      @(posedge clk); #1;
      va = 1'b0; vb = 1'b0;
   endtask
   task automatic wait_result(input string nm, input logic [63:0] es, input logic [63:0] eu,
                              input int ls_exp, input int lu_exp);
      int ls, lu, ns, nu;
      ls = 0; lu = 0; ns = 0; nu = 0;
      for (int c = 1; c <= 40; c++) begin
         @(posedge clk); #1;
         if (s_v) begin
            ns++;
            if (ls == 0) begin ls = c; chk({nm, "_sdata"}, s_d, es); end
         end
         if (u_v) begin
            nu++;
            if (lu == 0) begin lu = c; chk({nm, "_udata"}, u_d, eu); end
         end
      end
      chk({nm, "_slat"}, ls, ls_exp);
      chk({nm, "_ulat"}, lu, lu_exp);
      chk({nm, "_spulse"}, ns, 1);
      chk({nm, "_upulse"}, nu, 1);
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end
   initial begin
      int n;
      tbl[0]  = '{32'd100,      32'd7,        64'h0000000E_00000002, 64'h0000000E_00000002};
      tbl[1]  = '{32'hFFFFFFF9, 32'd2,        64'hFFFFFFFD_FFFFFFFF, 64'h7FFFFFFC_00000001};
      tbl[2]  = '{32'd7,        32'hFFFFFFFE, 64'hFFFFFFFD_00000001, 64'h00000000_00000007};
      tbl[3]  = '{32'd5,        32'd0,        64'hFFFFFFFF_00000005, 64'hFFFFFFFF_00000005};
      tbl[4]  = '{32'h80000000, 32'hFFFFFFFF, 64'h80000000_00000000, 64'h00000000_80000000};
      tbl[5]  = '{32'hFFFFFFFB, 32'd0,        64'hFFFFFFFF_FFFFFFFB, 64'hFFFFFFFF_FFFFFFFB};
      tbl[6]  = '{32'd9,        32'd3,        64'h00000003_00000000, 64'h00000003_00000000};
      tbl[7]  = '{32'd3,        32'd10,       64'h00000000_00000003, 64'h00000000_00000003};
      tbl[8]  = '{32'hFFFFFFF9, 32'hFFFFFFFE, 64'h00000003_FFFFFFFF, 64'h00000000_FFFFFFF9};
      tbl[9]  = '{32'hFFFFFFFF, 32'd1,        64'hFFFFFFFF_00000000, 64'hFFFFFFFF_00000000};
      tbl[10] = '{32'h12345678, 32'h10,       64'h01234567_00000008, 64'h01234567_00000008};
      tbl[11] = '{32'h80000000, 32'd2,        64'hC0000000_00000000, 64'h40000000_00000000};
      resetn = 1'b0; va = 1'b1; vb = 1'b1; rdy = 1'b1; cancel = 1'b0; a = 32'd1; b = 32'd1;
      #1;
      chk("rst_rdy", {s_ra, s_rb, u_ra, u_rb}, 4'h0);
      chk("rst_valid", {s_v, u_v}, 2'b00);
      chk("rst_sdata", s_d, 64'h0);
      chk("rst_udata", u_d, 64'h0);
      va = 1'b0; vb = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk) resetn = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 12; i++) begin
         issue($sformatf("vec%0d", i), tbl[i].a, tbl[i].b);
         wait_result($sformatf("vec%0d", i), tbl[i].es, tbl[i].eu,
                     exp_lat(tbl[i].a, tbl[i].b, 1'b1), exp_lat(tbl[i].a, tbl[i].b, 1'b0));
      end
      a = 32'd10; b = 32'd2; vb = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1 chk("single_rdy", {s_ra, s_rb, u_ra, u_rb}, 4'h0);
         @(posedge clk); #1;
      end
      vb = 1'b0;
      repeat (3) @(posedge clk);
      #1 chk("single_valid", {s_v, u_v}, 2'b00);
      rdy = 1'b0;
      issue("bp", 32'd100, 32'd7);
      a = 32'd9; b = 32'd3; va = 1'b1; vb = 1'b1;
      n = 0;
      while (!s_v && n < 40) begin @(posedge clk); #1; n++; end
      chk("bp_lat", n, 33);
      for (int i = 0; i < 5; i++) begin
         chk("bp_hold", {s_v, u_v, s_ra, s_rb, u_ra, u_rb}, 6'b110000);
         chk("bp_sdata", s_d, 64'h0000000E_00000002);
         chk("bp_udata", u_d, 64'h0000000E_00000002);
         @(posedge clk); #1;
      end
      rdy = 1'b1;
      #1 chk("bp_release_rdy", {s_ra, s_rb, u_ra, u_rb}, 4'h0);
      @(posedge clk); #1;
      chk("bp_drop", {s_v, u_v}, 2'b00);
      chk("bp_idle_rdy", {s_ra, s_rb, u_ra, u_rb}, 4'hF);
      chk("bp_keep", s_d, 64'h0000000E_00000002);
      @(posedge clk); #1;
      va = 1'b0; vb = 1'b0;
      wait_result("bp2", 64'h00000003_00000000, 64'h00000003_00000000, 33, 33);
      issue("cn", 32'd1000, 32'd7);
      repeat (10) @(posedge clk);
      #1 cancel = 1'b1; a = 32'd9; b = 32'd3; va = 1'b1; vb = 1'b1;
      #1 chk("cn_block", {s_ra, s_rb, u_ra, u_rb}, 4'h0);
      @(posedge clk); #1;
      cancel = 1'b0;
      issue("cn_next", 32'd9, 32'd3);
      wait_result("cn_res", 64'h00000003_00000000, 64'h00000003_00000000, 33, 33);
      rdy = 1'b0;
      issue("cd", 32'd100, 32'd7);
      n = 0;
      while (!s_v && n < 40) begin @(posedge clk); #1; n++; end
      chk("cd_lat", n, 33);
      cancel = 1'b1;
      @(posedge clk); #1;
      cancel = 1'b0;
      chk("cd_valid", {s_v, u_v}, 2'b00);
      rdy = 1'b1;
      issue("rs", 32'd50, 32'd3);
      repeat (5) @(posedge clk);
      #2 resetn = 1'b0; va = 1'b1; vb = 1'b1;
      #1;
      chk("rs_valid", {s_v, u_v}, 2'b00);
      chk("rs_rdy", {s_ra, s_rb, u_ra, u_rb}, 4'h0);
      chk("rs_sdata", s_d, 64'h0);
      chk("rs_udata", u_d, 64'h0);
      va = 1'b0; vb = 1'b0;
      @(negedge clk) resetn = 1'b1;
      @(posedge clk); #1;
      issue("post", 32'd50, 32'd3);
      wait_result("post", 64'h00000010_00000002, 64'h00000010_00000002, 33, 33);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
